switch_debounce_pulse: RTL and testbench



---
 rtl/switch_debounce_pulse.sv | 112 +++++++++++
 tb/tb_switch_debounce_pulse.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_pulse.sv
// switch_debounce_pulse: synchronizes and debounces raw DE2 switch/key lines,
// producing clean levels plus single-cycle edge pulses for the JK flip-flop
// stage. Optional build macro FALL_PULSE_EN enables falling-edge pulses;
// without it fall_pulse is tied low and any_change reflects rises only.
module switch_debounce_pulse #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned CNT_MAX     = 500000,
  parameter int unsigned CNT_W       = 19,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  // Last count value before a mismatched level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_c;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  level_q, level_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic                              any_q, any_d;

  // Synchronizer chain: stage 0 samples the raw pins, each later stage copies the previous one.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = raw_in;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Per-channel debounce: count while the synchronized line disagrees with
  // the accepted level, accept it on the terminal count, clear on any glitch.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync_c[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = sync_c[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Rising-edge detect on the accepted level, registered with the level update.
  always_comb begin
    rise_d = level_d & ~level_q;
  end

`ifdef FALL_PULSE_EN
  logic [WIDTH-1:0] fall_q, fall_d;

  // Falling-edge detect and combined change flag including falls.
  always_comb begin
    fall_d = ~level_d & level_q;
    any_d  = (|rise_d) | (|fall_d);
  end

  // Falling-edge pulse register.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign fall_pulse = fall_q;
`else
  // Change flag reflects rises only when falling pulses are not built.
  always_comb begin
    any_d = |rise_d;
  end

  assign fall_pulse = '0;
`endif

  // State registers for synchronizer, counters, level and rising pulses.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      any_q   <= any_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// Directed bench for switch_debounce_pulse with CNT_MAX=4, SYNC_STAGES=2, WIDTH=5.
module tb_switch_debounce_pulse;

`ifdef FALL_PULSE_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic       CLOCK_50;
  logic       RST_N;
  logic [4:0] raw_in;
  logic [4:0] level_out, rise_pulse, fall_pulse;
  logic       any_change;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  switch_debounce_pulse #(
    .WIDTH(5), .CNT_MAX(4), .CNT_W(19), .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RST_N     (RST_N),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%b expected=%b", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int idx, input logic [4:0] lvl,
                           input logic [4:0] rise, input logic [4:0] fall, input logic any);
    check({nm, ".level"}, idx, level_out, lvl);
    check({nm, ".rise"},  idx, rise_pulse, rise);
    check({nm, ".fall"},  idx, fall_pulse, fall);
    check({nm, ".any"},   idx, {4'b0, any_change}, {4'b0, any});
  endtask

  // Append n identical one-edge vectors; fall expectations masked by the build option.
  task automatic add(input logic [4:0] raw, input logic [4:0] lvl, input logic [4:0] rise,
                     input logic [4:0] fall, input int n);
    vec_t v;
    v.raw  = raw;
    v.lvl  = lvl;
    v.rise = rise;
    v.fall = FE ? fall : 5'b0;
    v.any  = (rise != 5'b0) || (FE && (fall != 5'b0));
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      raw_in = tbl[i].raw;
      @(posedge CLOCK_50); #1;
      check_all(nm, i, tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].any);
    end
    tbl.delete();
  endtask

  initial begin
    RST_N  = 1'b0;
    raw_in = 5'b11111;
    #2;
    // Reset asserted before any clock edge: outputs must already be cleared.
    check_all("reset_async", 0, 5'b0, 5'b0, 5'b0, 1'b0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_all("reset_hold", 0, 5'b0, 5'b0, 5'b0, 1'b0);
    RST_N = 1'b1;

    // Inputs high through reset: accepted six edges after release.
    add(5'b11111, 5'b00000, 5'b00000, 5'b0, 5);
    add(5'b11111, 5'b11111, 5'b11111, 5'b0, 1);
    add(5'b11111, 5'b11111, 5'b00000, 5'b0, 1);
    run_table("reset_release");

    // All released.
    add(5'b00000, 5'b11111, 5'b0, 5'b0,     5);
    add(5'b00000, 5'b00000, 5'b0, 5'b11111, 1);
    add(5'b00000, 5'b00000, 5'b0, 5'b0,     2);
    run_table("release_all");

    // Glitch on channel 0 for three cycles is rejected.
    add(5'b00001, 5'b0, 5'b0, 5'b0, 3);
    add(5'b00000, 5'b0, 5'b0, 5'b0, 6);
    run_table("glitch");

    // Clean press on channel 2.
    add(5'b00100, 5'b00000, 5'b00000, 5'b0, 5);
    add(5'b00100, 5'b00100, 5'b00100, 5'b0, 1);
    add(5'b00100, 5'b00100, 5'b00000, 5'b0, 1);
    run_table("clean_press");

    // Bounce on channel 1 (1,0,1,0,1 then held), channel 2 stays high.
    add(5'b00110, 5'b00100, 5'b0, 5'b0, 1);
    add(5'b00100, 5'b00100, 5'b0, 5'b0, 1);
    add(5'b00110, 5'b00100, 5'b0, 5'b0, 1);
    add(5'b00100, 5'b00100, 5'b0, 5'b0, 1);
    add(5'b00110, 5'b00100, 5'b0, 5'b0, 5);
    add(5'b00110, 5'b00110, 5'b00010, 5'b0, 1);
    add(5'b00110, 5'b00110, 5'b00000, 5'b0, 2);
    run_table("bounce");

    // Simultaneous rises on channels 0, 3, 4.
    add(5'b11111, 5'b00110, 5'b00000, 5'b0, 5);
    add(5'b11111, 5'b11111, 5'b11001, 5'b0, 1);
    add(5'b11111, 5'b11111, 5'b00000, 5'b0, 1);
    run_table("multi_rise");

    // Channels 0 and 4 released together.
    add(5'b01110, 5'b11111, 5'b0, 5'b0,     5);
    add(5'b01110, 5'b01110, 5'b0, 5'b10001, 1);
    add(5'b01110, 5'b01110, 5'b0, 5'b0,     1);
    run_table("release_04");

    add(5'b00000, 5'b01110, 5'b0, 5'b0,     5);
    add(5'b00000, 5'b00000, 5'b0, 5'b01110, 1);
    add(5'b00000, 5'b00000, 5'b0, 5'b0,     2);
    run_table("release_rest");

    // Channel 3: two sync edges plus three counting edges, then reset for one cycle.
    add(5'b01000, 5'b0, 5'b0, 5'b0, 5);
    run_table("midcount_pre");
    RST_N = 1'b0;
    @(posedge CLOCK_50); #1;
    // This edge would have accepted the level without the reset.
    check_all("midcount_in_reset", 0, 5'b0, 5'b0, 5'b0, 1'b0);
    RST_N = 1'b1;
    add(5'b01000, 5'b00000, 5'b00000, 5'b0, 5);
    add(5'b01000, 5'b01000, 5'b01000, 5'b0, 1);
    add(5'b01000, 5'b01000, 5'b00000, 5'b0, 1);
    run_table("midcount_post");

    // Asynchronous reset mid-cycle while a level is held high.
    #5;
    RST_N = 1'b0;
    #1;
    check_all("reset_async_live", 0, 5'b0, 5'b0, 5'b0, 1'b0);
    @(posedge CLOCK_50); #1;
    RST_N = 1'b1;
    add(5'b01000, 5'b00000, 5'b00000, 5'b0, 5);
    add(5'b01000, 5'b01000, 5'b01000, 5'b0, 1);
    add(5'b01000, 5'b01000, 5'b00000, 5'b0, 1);
    run_table("rerise_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
